mark_sequencer: RTL and testbench

Owns the 25-bit circle vector and the completed-line count that feed the display top. Accepts "mark number N" requests from two requesters, the local player and the remote board link, with round-robin arbitration. Searches the 5x5 map serially for the cell holding N, sets its circle bit, then recounts the 12 bingo lines serially. Drives circle, the BCD line count on display_nums, and the bingo flag.

---
 rtl/mark_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_mark_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mark_sequencer.sv
// Marks requested numbers on the 5x5 bingo board and keeps the completed-line count.
// Two requesters share one serial scan/update/count engine through a round-robin grant.
module mark_sequencer #(
    parameter int LINES_TO_WIN = 5,
    parameter int NUM_W        = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_W*25-1:0] map,
    input  logic               clear_board,
    input  logic               req_local,
    input  logic [NUM_W-1:0]   num_local,
    input  logic               req_remote,
    input  logic [NUM_W-1:0]   num_remote,
    output logic               ack_local,
    output logic               ack_remote,
    output logic               busy,
    output logic               done,
    output logic               hit,
    output logic [24:0]        circle,
    output logic [3:0]         lines,
    output logic [7:0]         display_nums,
    output logic               bingo
);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_UPDATE, S_COUNT, S_DONE} state_t;

    state_t           state_q;
    logic [NUM_W-1:0] num_q;
    logic [4:0]       idx_q;
    logic [4:0]       match_q;
    logic             found_q;
    logic             hit_r_q;
    logic [3:0]       k_q;
    logic [3:0]       acc_q;
    logic             rr_q;
    logic [24:0]      circle_q;
    logic [3:0]       lines_q;
    logic [7:0]       disp_q;
    logic             bingo_q;
    logic             ack_local_q;
    logic             ack_remote_q;
    logic             busy_q;
    logic             done_q;
    logic             hit_q;

    // Lines 0..4 are rows, 5..9 columns, 10 the main diagonal, 11 the anti-diagonal.
    function automatic logic [24:0] line_mask(input logic [3:0] k);
        logic [24:0] m;
        int          kk;
        m  = '0;
        kk = int'(k);
        for (int j = 0; j < 5; j++) begin
            if (kk < 5)
                m[kk*5 + j] = 1'b1;
            else if (kk < 10)
                m[(kk-5) + j*5] = 1'b1;
            else if (kk == 10)
                m[j*6] = 1'b1;
            else if (kk == 11)
                m[4 + j*4] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [3:0] n);
        logic [7:0] r;
        if (n >= 4'd10)
            r = {4'h1, n - 4'd10};
        else
            r = {4'h0, n};
        return r;
    endfunction

    logic [NUM_W-1:0] cell_d;
    logic [24:0]      mask_d;
    logic             line_full_d;
    logic [3:0]       count_d;
    logic             grant_local_d;

    always_comb begin
        cell_d        = map[int'(idx_q)*NUM_W +: NUM_W];
        mask_d        = line_mask(k_q);
        line_full_d   = ((circle_q & mask_d) == mask_d);
        count_d       = acc_q + {3'b000, line_full_d};
        // rr_q == 0 gives local the tie; it only moves when both sides contend.
        grant_local_d = req_local & (~req_remote | ~rr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            idx_q        <= '0;
            match_q      <= '0;
            found_q      <= 1'b0;
            hit_r_q      <= 1'b0;
            k_q          <= '0;
            acc_q        <= '0;
            rr_q         <= 1'b0;
            circle_q     <= '0;
            lines_q      <= '0;
            disp_q       <= '0;
            bingo_q      <= 1'b0;
            ack_local_q  <= 1'b0;
            ack_remote_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            ack_local_q  <= 1'b0;
            ack_remote_q <= 1'b0;
            done_q       <= 1'b0;
            hit_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear_board) begin
                        circle_q <= '0;
                        lines_q  <= '0;
                        disp_q   <= '0;
                        bingo_q  <= 1'b0;
                    end else if (req_local || req_remote) begin
                        num_q        <= grant_local_d ? num_local : num_remote;
                        ack_local_q  <= grant_local_d;
                        ack_remote_q <= ~grant_local_d;
                        if (req_local && req_remote)
                            rr_q <= ~rr_q;
                        idx_q        <= '0;
                        match_q      <= '0;
                        found_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!found_q && (cell_d == num_q)) begin
                        found_q <= 1'b1;
                        match_q <= idx_q;
                    end
                    if (idx_q == 5'd24)
                        state_q <= S_UPDATE;
                    else
                        idx_q <= idx_q + 5'd1;
                end
                S_UPDATE: begin
                    hit_r_q <= found_q & ~circle_q[match_q];
                    if (found_q)
                        circle_q[match_q] <= 1'b1;
                    k_q     <= '0;
                    acc_q   <= '0;
                    state_q <= S_COUNT;
                end
                S_COUNT: begin
                    if (k_q == 4'd11) begin
                        lines_q <= count_d;
                        disp_q  <= to_bcd(count_d);
                        bingo_q <= (int'(count_d) >= LINES_TO_WIN);
                        state_q <= S_DONE;
                    end else begin
                        acc_q <= count_d;
                        k_q   <= k_q + 4'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    hit_q   <= hit_r_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack_local    = ack_local_q;
    assign ack_remote   = ack_remote_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign hit          = hit_q;
    assign circle       = circle_q;
    assign lines        = lines_q;
    assign display_nums = disp_q;
    assign bingo        = bingo_q;

endmodule

// File: tb/tb_mark_sequencer.sv
// Directed bench for mark_sequencer: marking, line counting, arbitration, clear and reset.
module tb_mark_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [124:0] map = '0;
    logic         clear_board = 1'b0;
    logic         req_local = 1'b0;
    logic [4:0]   num_local = '0;
    logic         req_remote = 1'b0;
    logic [4:0]   num_remote = '0;
    logic         ack_local, ack_remote, busy, done, hit, bingo;
    logic [24:0]  circle;
    logic [3:0]   lines;
    logic [7:0]   display_nums;

    int checks = 0;
    int fails  = 0;
    logic [24:0] model_circle = '0;

    mark_sequencer #(.LINES_TO_WIN(5), .NUM_W(5)) dut (
        .clk(clk), .rst(rst), .map(map), .clear_board(clear_board),
        .req_local(req_local), .num_local(num_local),
        .req_remote(req_remote), .num_remote(num_remote),
        .ack_local(ack_local), .ack_remote(ack_remote), .busy(busy), .done(done),
        .hit(hit), .circle(circle), .lines(lines), .display_nums(display_nums),
        .bingo(bingo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_lines(input logic [24:0] c);
        int n = 0;
        bit r, cl, d, a;
        for (int y = 0; y < 5; y++) begin
            r = 1'b1; cl = 1'b1;
            for (int x = 0; x < 5; x++) begin
                r  = r  & c[y*5 + x];
                cl = cl & c[x*5 + y];
            end
            n = n + int'(r) + int'(cl);
        end
        d = 1'b1; a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = d & c[i*6];
            a = a & c[4 + i*4];
        end
        return n + int'(d) + int'(a);
    endfunction

    function automatic logic [7:0] model_bcd(input int n);
        logic [7:0] r;
        r = (n >= 10) ? 8'(16 + n - 10) : 8'(n);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc, output bit to);
        cyc = 0; to = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done === 1'b1) begin
                cyc = c; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_mark(input bit remote, input logic [4:0] n, output logic h,
                           output int alat, output int dlat, output bit to);
        h = 1'b0; alat = 0; dlat = 0; to = 1'b0;
        if (remote) begin req_remote = 1'b1; num_remote = n; end
        else begin req_local = 1'b1; num_local = n; end
        for (int c = 1; c <= 5; c++) begin
            tick();
            if ((remote ? ack_remote : ack_local) === 1'b1) begin
                alat = c;
                break;
            end
        end
        req_local = 1'b0; req_remote = 1'b0;
        if (alat == 0) begin to = 1'b1; return; end
        wait_done(dlat, to);
        h = hit;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 25; i++) map[i*5 +: 5] = 5'(i + 1);
        tick(); tick();
        checks++; if (circle !== 25'h0) begin fails++; $display("FAIL reset_circle: got %h expected %h", circle, 25'h0); end
        checks++; if (lines !== 4'h0) begin fails++; $display("FAIL reset_lines: got %h expected 0", lines); end
        checks++; if (display_nums !== 8'h00) begin fails++; $display("FAIL reset_display: got %h expected 00", display_nums); end
        checks++; if ({bingo, busy, done, hit, ack_local, ack_remote} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got %b expected 000000", {bingo, busy, done, hit, ack_local, ack_remote}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_mark();
        logic h; int al, dl; bit to;
        do_mark(1'b0, 5'd13, h, al, dl, to);
        model_circle[12] = 1'b1;
        checks++; if (to) begin fails++; $display("FAIL first_timeout: got timeout expected completion"); end
        checks++; if (al != 1) begin fails++; $display("FAIL first_ack_latency: got %0d expected 1", al); end
        checks++; if (dl != 39) begin fails++; $display("FAIL first_done_latency: got %0d expected 39", dl); end
        checks++; if (h !== 1'b1) begin fails++; $display("FAIL first_hit: got %b expected 1", h); end
        checks++; if (circle !== 25'h0001000) begin fails++; $display("FAIL first_circle: got %h expected 0001000", circle); end
        checks++; if (lines !== 4'd0 || display_nums !== 8'h00) begin
            fails++; $display("FAIL first_lines: got %0d/%h expected 0/00", lines, display_nums); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL first_busy_at_done: got %b expected 0", busy); end
    endtask

    task automatic test_row_col();
        logic h; int al, dl; bit to;
        logic [4:0] col_nums [4] = '{5'd6, 5'd11, 5'd16, 5'd21};
        for (int n = 1; n <= 5; n++) begin
            do_mark(1'b0, 5'(n), h, al, dl, to);
            model_circle[n-1] = 1'b1;
        end
        checks++; if (circle[4:0] !== 5'h1F) begin fails++; $display("FAIL row_circle: got %h expected 1f", circle[4:0]); end
        checks++; if (lines !== 4'd1 || bingo !== 1'b0) begin
            fails++; $display("FAIL row_lines: got %0d bingo %b expected 1 bingo 0", lines, bingo); end
        for (int i = 0; i < 4; i++) begin
            do_mark(1'b0, col_nums[i], h, al, dl, to);
            model_circle[col_nums[i]-1] = 1'b1;
        end
        checks++; if (lines !== 4'd2 || display_nums !== 8'h02) begin
            fails++; $display("FAIL col_lines: got %0d/%h expected 2/02", lines, display_nums); end
        checks++; if (circle !== model_circle) begin fails++; $display("FAIL col_circle: got %h expected %h", circle, model_circle); end
    endtask

    task automatic test_arbitration();
        int dl; bit to; int al;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        model_circle = '0;
        req_local = 1'b1; num_local = 5'd7; req_remote = 1'b1; num_remote = 5'd9;
        tick();
        checks++; if (ack_local !== 1'b1 || ack_remote !== 1'b0) begin
            fails++; $display("FAIL arb_first_grant: got local %b remote %b expected 1 0", ack_local, ack_remote); end
        req_local = 1'b0;
        wait_done(dl, to);
        checks++; if (to || dl != 39) begin fails++; $display("FAIL arb_first_done: got %0d expected 39", dl); end
        checks++; if (ack_remote !== 1'b0) begin fails++; $display("FAIL arb_remote_early: got %b expected 0", ack_remote); end
        tick();
        checks++; if (ack_remote !== 1'b1) begin fails++; $display("FAIL arb_remote_after_done: got %b expected 1", ack_remote); end
        req_remote = 1'b0;
        wait_done(dl, to);
        checks++; if (to || hit !== 1'b1) begin fails++; $display("FAIL arb_remote_hit: got %b expected 1", hit); end
        req_local = 1'b1; num_local = 5'd8; req_remote = 1'b1; num_remote = 5'd10;
        tick();
        checks++; if (ack_remote !== 1'b1 || ack_local !== 1'b0) begin
            fails++; $display("FAIL arb_second_grant: got local %b remote %b expected 0 1", ack_local, ack_remote); end
        req_remote = 1'b0;
        wait_done(dl, to);
        al = 0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (ack_local === 1'b1) begin al = c; break; end
        end
        checks++; if (al != 1) begin fails++; $display("FAIL arb_local_pending: got latency %0d expected 1", al); end
        req_local = 1'b0;
        wait_done(dl, to);
        model_circle[6] = 1'b1; model_circle[7] = 1'b1; model_circle[8] = 1'b1; model_circle[9] = 1'b1;
        checks++; if (to || circle !== 25'h00003C0) begin fails++; $display("FAIL arb_circle: got %h expected 00003c0", circle); end
    endtask

    task automatic test_full_board();
        logic h; int al, dl; bit to;
        int exp_lines;
        for (int n = 1; n <= 25; n++) begin
            do_mark(n[0], 5'(n), h, al, dl, to);
            checks++; if (to || h !== !model_circle[n-1]) begin
                fails++; $display("FAIL full_hit_%0d: got %b expected %b", n, h, !model_circle[n-1]); end
            model_circle[n-1] = 1'b1;
            exp_lines = model_lines(model_circle);
            checks++; if (lines !== 4'(exp_lines) || bingo !== (exp_lines >= 5)) begin
                fails++; $display("FAIL full_lines_%0d: got %0d bingo %b expected %0d", n, lines, bingo, exp_lines); end
        end
        checks++; if (lines !== 4'd12 || display_nums !== 8'h12 || bingo !== 1'b1) begin
            fails++; $display("FAIL full_final: got %0d/%h bingo %b expected 12/12 bingo 1", lines, display_nums, bingo); end
        checks++; if (circle !== 25'h1FFFFFF) begin fails++; $display("FAIL full_circle: got %h expected 1ffffff", circle); end
        do_mark(1'b0, 5'd13, h, al, dl, to);
        checks++; if (to || h !== 1'b0 || lines !== 4'd12) begin
            fails++; $display("FAIL remark_13: got hit %b lines %0d expected 0 12", h, lines); end
    endtask

    task automatic test_invalid_and_clear();
        logic h; int al, dl; bit to;
        do_mark(1'b0, 5'd0, h, al, dl, to);
        checks++; if (to || h !== 1'b0 || circle !== 25'h1FFFFFF) begin
            fails++; $display("FAIL num_zero: got hit %b circle %h expected 0 1ffffff", h, circle); end
        req_local = 1'b1; num_local = 5'd31;
        tick();
        req_local = 1'b0;
        repeat (5) tick();
        clear_board = 1'b1; tick(); clear_board = 1'b0;
        wait_done(dl, to);
        checks++; if (to || hit !== 1'b0 || circle !== 25'h1FFFFFF || lines !== 4'd12) begin
            fails++; $display("FAIL clear_while_busy: got hit %b circle %h lines %0d expected 0 1ffffff 12", hit, circle, lines); end
        clear_board = 1'b1; req_local = 1'b1; num_local = 5'd3;
        tick();
        checks++; if (circle !== 25'h0 || lines !== 4'd0 || display_nums !== 8'h00 || bingo !== 1'b0) begin
            fails++; $display("FAIL clear_idle: got circle %h lines %0d disp %h bingo %b expected all 0", circle, lines, display_nums, bingo); end
        checks++; if (ack_local !== 1'b0) begin fails++; $display("FAIL clear_no_ack: got %b expected 0", ack_local); end
        clear_board = 1'b0;
        tick();
        checks++; if (ack_local !== 1'b1) begin fails++; $display("FAIL clear_then_ack: got %b expected 1", ack_local); end
        req_local = 1'b0;
        wait_done(dl, to);
        checks++; if (to || hit !== 1'b1 || circle !== 25'h0000004) begin
            fails++; $display("FAIL after_clear_mark: got hit %b circle %h expected 1 0000004", hit, circle); end
    endtask

    task automatic test_reset_mid();
        logic h; int al, dl; bit to;
        int seen;
        req_local = 1'b1; num_local = 5'd20;
        tick();
        checks++; if (ack_local !== 1'b1) begin fails++; $display("FAIL mid_ack: got %b expected 1", ack_local); end
        req_local = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        checks++; if (circle !== 25'h0 || lines !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL mid_reset: got circle %h lines %0d busy %b done %b expected 0", circle, lines, busy, done); end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin fails++; $display("FAIL mid_no_done: got %0d pulses expected 0", seen); end
        do_mark(1'b0, 5'd20, h, al, dl, to);
        checks++; if (to || dl != 39 || h !== 1'b1 || circle !== 25'h0080000 || lines !== 4'd0) begin
            fails++; $display("FAIL mid_recover: got lat %0d hit %b circle %h lines %0d expected 39 1 0080000 0", dl, h, circle, lines); end
    endtask

    initial begin
        test_reset();
        test_first_mark();
        test_row_col();
        test_arbitration();
        test_full_board();
        test_invalid_and_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
